// File: rtl/dma_addr_gen_mc.sv
// ============================================================================
//  Module      : dma_addr_gen_mc
//  Description : Multi-channel DMA address / word-count generator with
//                auto-reload and stop-at-done counting.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dma_addr_gen_mc #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CH_W-1:0]     chan,
    input  logic [2:0]          instruction,
    input  logic [WIDTH-1:0]    data_in,
    output logic [WIDTH-1:0]    data_out,
    output logic                data_oe,
    input  logic                oena,
    input  logic                cinac,
    input  logic                cinwc,
    output logic [WIDTH-1:0]    output_address,
    output logic                conac,
    output logic                conwc,
    output logic [CHANNELS-1:0] done
);

    localparam logic [2:0] c_op_wrcr   = 3'd0;
    localparam logic [2:0] c_op_rdcr   = 3'd1;
    localparam logic [2:0] c_op_rdwc   = 3'd2;
    localparam logic [2:0] c_op_rdac   = 3'd3;
    localparam logic [2:0] c_op_reinit = 3'd4;
    localparam logic [2:0] c_op_ldaddr = 3'd5;
    localparam logic [2:0] c_op_ldwc   = 3'd6;
    localparam logic [2:0] c_op_enct   = 3'd7;

    localparam logic [1:0] c_mode_dn   = 2'b00;
    localparam logic [1:0] c_mode_up   = 2'b01;
    localparam logic [1:0] c_mode_addr = 2'b10;
    localparam logic [1:0] c_mode_free = 2'b11;

    localparam logic [CH_W:0] c_chans = (CH_W+1)'(CHANNELS);

    logic                              w_valid;
    logic [CHANNELS-1:0][3:0]          w_cr_all;
    logic [CHANNELS-1:0][WIDTH-1:0]    w_ac_all;
    logic [CHANNELS-1:0][WIDTH-1:0]    w_wc_all;

    assign w_valid = ({1'b0, chan} < c_chans);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [3:0]       r_cr;
            logic [WIDTH-1:0] r_ac;
            logic [WIDTH-1:0] r_ar;
            logic [WIDTH-1:0] r_wc;
            logic [WIDTH-1:0] r_wcr;
            logic             w_sel;
            logic             w_done;
            logic             w_stopping;
            logic [1:0]       w_mode;

            assign w_sel  = w_valid && (chan == CH_W'(i));
            assign w_mode = r_cr[1:0];

            always_comb begin
                w_done = 1'b0;
                case (w_mode)
                    c_mode_dn:   w_done = (r_wc == WIDTH'(1));
                    c_mode_up:   w_done = (r_wc == r_wcr);
                    c_mode_addr: w_done = (r_ac == r_wcr);
                    default:     w_done = (r_wc == WIDTH'(1));
                endcase
            end

            // Free-running mode never stops or reloads; it simply wraps.
            assign w_stopping = (w_mode != c_mode_free) && w_done;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cr  <= '0;
                    r_ac  <= '0;
                    r_ar  <= '0;
                    r_wc  <= '0;
                    r_wcr <= '0;
                end else if (w_sel) begin
                    case (instruction)
                        c_op_wrcr: r_cr <= data_in[3:0];
                        c_op_reinit: begin
                            r_ac <= r_ar;
                            r_wc <= (w_mode == c_mode_up) ? '0 : r_wcr;
                        end
                        c_op_ldaddr: begin
                            r_ac <= data_in;
                            r_ar <= data_in;
                        end
                        c_op_ldwc: begin
                            r_wcr <= data_in;
                            r_wc  <= (w_mode == c_mode_up) ? '0 : data_in;
                        end
                        c_op_enct: begin
                            if (w_stopping && r_cr[3]) begin
                                r_ac <= r_ar;
                                r_wc <= (w_mode == c_mode_up) ? '0 : r_wcr;
                            end else if (!w_stopping) begin
                                if (!cinac)
                                    r_ac <= r_cr[2] ? (r_ac - WIDTH'(1)) : (r_ac + WIDTH'(1));
                                if (!cinwc) begin
                                    case (w_mode)
                                        c_mode_up:   r_wc <= r_wc + WIDTH'(1);
                                        c_mode_addr: r_wc <= r_wc;
                                        default:     r_wc <= r_wc - WIDTH'(1);
                                    endcase
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign done[i]     = w_done;
            assign w_cr_all[i] = r_cr;
            assign w_ac_all[i] = r_ac;
            assign w_wc_all[i] = r_wc;
        end
    endgenerate

    logic [3:0]       w_cr;
    logic [WIDTH-1:0] w_ac;
    logic [WIDTH-1:0] w_wc;
    logic             w_enct;

    always_comb begin
        w_cr = '0;
        w_ac = '0;
        w_wc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_valid && (chan == CH_W'(i))) begin
                w_cr = w_cr_all[i];
                w_ac = w_ac_all[i];
                w_wc = w_wc_all[i];
            end
        end
    end

    assign w_enct  = w_valid && (instruction == c_op_enct);
    assign data_oe = w_valid && ((instruction == c_op_rdcr) ||
                                 (instruction == c_op_rdwc) ||
                                 (instruction == c_op_rdac));

    always_comb begin
        data_out = '0;
        if (w_valid) begin
            case (instruction)
                c_op_rdcr: data_out = {{(WIDTH-4){1'b0}}, w_cr};
                c_op_rdwc: data_out = w_wc;
                c_op_rdac: data_out = w_ac;
                default:   data_out = '0;
            endcase
        end
    end

    assign output_address = (w_valid && !oena) ? w_ac : '0;

    assign conac = !(w_enct && !cinac &&
                     (w_cr[2] ? (w_ac == '0) : (w_ac == '1)));

    // Word-count carry follows the count direction of the mode; held mode never carries.
    assign conwc = !(w_enct && !cinwc && (w_cr[1:0] != c_mode_addr) &&
                     ((w_cr[1:0] == c_mode_up) ? (w_wc == '1) : (w_wc == '0)));

endmodule

`default_nettype wire

// File: tb/tb_dma_addr_gen_mc.sv
// ============================================================================
//  Module      : tb_dma_addr_gen_mc
//  Description : Self-checking bench for dma_addr_gen_mc (tables, corner
//                sequences and random stimulus against a reference model).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dma_addr_gen_mc;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   chan;
    logic [2:0]   instruction;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         data_oe;
    logic         oena;
    logic         cinac;
    logic         cinwc;
    logic [W-1:0] output_address;
    logic         conac;
    logic         conwc;
    logic [N-1:0] done;

    dma_addr_gen_mc #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .reset(reset), .chan(chan), .instruction(instruction),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
        .oena(oena), .cinac(cinac), .cinwc(cinwc),
        .output_address(output_address), .conac(conac), .conwc(conwc),
        .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]   m_cr  [N];
    logic [W-1:0] m_ac  [N];
    logic [W-1:0] m_ar  [N];
    logic [W-1:0] m_wc  [N];
    logic [W-1:0] m_wcr [N];

    logic [W-1:0] s_dout;
    logic         s_oe;
    logic [W-1:0] s_addr;
    logic         s_conac;
    logic [N-1:0] s_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic m_done(input int c);
        case (m_cr[c][1:0])
            2'b00:   return m_wc[c] == 8'd1;
            2'b01:   return m_wc[c] == m_wcr[c];
            2'b10:   return m_ac[c] == m_wcr[c];
            default: return m_wc[c] == 8'd1;
        endcase
    endfunction

    task automatic m_reinit(input int c);
        m_ac[c] = m_ar[c];
        m_wc[c] = (m_cr[c][1:0] == 2'b01) ? 8'd0 : m_wcr[c];
    endtask

    task automatic m_reset();
        for (int c = 0; c < N; c++) begin
            m_cr[c] = 0; m_ac[c] = 0; m_ar[c] = 0; m_wc[c] = 0; m_wcr[c] = 0;
        end
    endtask

    // Model state transition for one clock edge.
    task automatic m_clock(input logic rst, input int c, input logic [2:0] op,
                           input logic [W-1:0] d, input logic ca, input logic cw);
        int md;
        if (rst) begin
            m_reset();
            return;
        end
        md = int'(m_cr[c][1:0]);
        case (op)
            3'd0: m_cr[c] = d[3:0];
            3'd4: m_reinit(c);
            3'd5: begin m_ac[c] = d; m_ar[c] = d; end
            3'd6: begin m_wcr[c] = d; m_wc[c] = (md == 1) ? 8'd0 : d; end
            3'd7: begin
                if (md != 3 && m_done(c)) begin
                    if (m_cr[c][3]) m_reinit(c);
                end else begin
                    if (!ca) m_ac[c] = m_cr[c][2] ? m_ac[c] - 8'd1 : m_ac[c] + 8'd1;
                    if (!cw) begin
                        if (md == 1)      m_wc[c] = m_wc[c] + 8'd1;
                        else if (md != 2) m_wc[c] = m_wc[c] - 8'd1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One instruction cycle: drive, compare outputs with the model, clock.
    task automatic apply(input logic rst, input int c, input logic [2:0] op,
                         input logic [W-1:0] d, input logic oe_n,
                         input logic ca, input logic cw);
        logic [W-1:0] e_dout;
        logic [N-1:0] e_done;
        logic         e_conac, e_conwc;
        int           md;
        @(negedge clk);
        reset = rst; chan = 2'(c); instruction = op; data_in = d;
        oena = oe_n; cinac = ca; cinwc = cw;
        #1;
        md = int'(m_cr[c][1:0]);
        case (op)
            3'd1:    e_dout = {4'd0, m_cr[c]};
            3'd2:    e_dout = m_wc[c];
            3'd3:    e_dout = m_ac[c];
            default: e_dout = 0;
        endcase
        for (int k = 0; k < N; k++) e_done[k] = m_done(k);
        e_conac = !(op == 3'd7 && !ca && (m_cr[c][2] ? m_ac[c] == 8'h00 : m_ac[c] == 8'hFF));
        e_conwc = !(op == 3'd7 && !cw && md != 2 &&
                    (md == 1 ? m_wc[c] == 8'hFF : m_wc[c] == 8'h00));
        check("data_out", 32'(data_out), 32'(e_dout));
        check("data_oe", 32'(data_oe), 32'(op >= 3'd1 && op <= 3'd3));
        check("output_address", 32'(output_address), oe_n ? 32'd0 : 32'(m_ac[c]));
        check("conac", 32'(conac), 32'(e_conac));
        check("conwc", 32'(conwc), 32'(e_conwc));
        check("done", 32'(done), 32'(e_done));
        s_dout = data_out; s_oe = data_oe; s_addr = output_address;
        s_conac = conac; s_done = done;
        @(posedge clk);
        m_clock(rst, c, op, d, ca, cw);
    endtask

    typedef struct {
        int           ch;
        logic [2:0]   op;
        logic [W-1:0] d;
        logic [W-1:0] exp_addr;
        logic         exp_done;
        logic         exp_conac;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int ch, input logic [2:0] op, input logic [W-1:0] d,
                       input logic [W-1:0] ea, input logic ed, input logic ec);
        vec_t v;
        v.ch = ch; v.op = op; v.d = d; v.exp_addr = ea; v.exp_done = ed; v.exp_conac = ec;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0] ac2 [8];
        int         pulses;
        reset = 1'b1; chan = 0; instruction = 3'd0; data_in = 0;
        oena = 1'b1; cinac = 1'b1; cinwc = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset data_out", 32'(data_out), 0);
        check("reset data_oe", 32'(data_oe), 0);
        check("reset output_address", 32'(output_address), 0);
        check("reset conac", 32'(conac), 1);
        check("reset conwc", 32'(conwc), 1);
        check("reset done", 32'(done), 0);

        // Ch0 stop mode: AC 1..9 then holds.
        add(0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        add(0, 3'd6, 8'h09, 8'h00, 1'b0, 1'b1);
        add(0, 3'd5, 8'h01, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++)
            add(0, 3'd7, 8'h00, 8'(1 + (i < 8 ? i : 8)), i >= 8, 1'b1);
        // Ch1 up-count mode: WC 0..9, AC 0x0F..0x18.
        add(1, 3'd0, 8'h01, 8'h00, 1'b0, 1'b1);
        add(1, 3'd6, 8'h09, 8'h00, 1'b1, 1'b1);
        add(1, 3'd5, 8'h0F, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++)
            add(1, 3'd7, 8'h00, 8'(15 + (i < 9 ? i : 9)), i >= 9, 1'b1);
        // Ch2 decrement with auto-reload.
        ac2 = '{8'h10, 8'h0F, 8'h0E, 8'h10, 8'h0F, 8'h0E, 8'h10, 8'h0F};
        add(2, 3'd0, 8'h0C, 8'h00, 1'b0, 1'b1);
        add(2, 3'd5, 8'h10, 8'h00, 1'b0, 1'b1);
        add(2, 3'd6, 8'h03, 8'h10, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++)
            add(2, 3'd7, 8'h00, ac2[i], ac2[i] == 8'h0E, 1'b1);
        // Ch3 address-compare mode across the 0xFF -> 0x00 wrap.
        add(3, 3'd0, 8'h02, 8'h00, 1'b0, 1'b1);
        add(3, 3'd5, 8'hFE, 8'h00, 1'b1, 1'b1);
        add(3, 3'd6, 8'h02, 8'hFE, 1'b0, 1'b1);
        add(3, 3'd7, 8'h00, 8'hFE, 1'b0, 1'b1);
        add(3, 3'd7, 8'h00, 8'hFF, 1'b0, 1'b0);
        add(3, 3'd7, 8'h00, 8'h00, 1'b0, 1'b1);
        add(3, 3'd7, 8'h00, 8'h01, 1'b0, 1'b1);
        add(3, 3'd7, 8'h00, 8'h02, 1'b1, 1'b1);
        add(3, 3'd7, 8'h00, 8'h02, 1'b1, 1'b1);

        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].ch, tbl[i].op, tbl[i].d, 1'b0, 1'b0, 1'b0);
            check($sformatf("tbl[%0d] addr", i), 32'(s_addr), 32'(tbl[i].exp_addr));
            check($sformatf("tbl[%0d] done", i), 32'(s_done[tbl[i].ch]), 32'(tbl[i].exp_done));
            check($sformatf("tbl[%0d] conac", i), 32'(s_conac), 32'(tbl[i].exp_conac));
        end

        apply(1'b0, 0, 3'd3, 8'h00, 1'b1, 1'b1, 1'b1);
        check("ch0 AC held", 32'(s_dout), 32'h09);
        apply(1'b0, 0, 3'd2, 8'h00, 1'b1, 1'b1, 1'b1);
        check("ch0 WC held", 32'(s_dout), 32'h01);
        apply(1'b0, 1, 3'd2, 8'h00, 1'b1, 1'b1, 1'b1);
        check("ch1 WC final", 32'(s_dout), 32'h09);

        // Mode 11 on ch0: single done pulse in 260 cycles, AC wraps freely.
        apply(1'b0, 0, 3'd0, 8'h07, 1'b1, 1'b1, 1'b1);
        apply(1'b0, 0, 3'd5, 8'hF1, 1'b1, 1'b1, 1'b1);
        apply(1'b0, 0, 3'd6, 8'hF8, 1'b1, 1'b1, 1'b1);
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            apply(1'b0, 0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
            if (s_done[0]) pulses++;
        end
        check("mode11 done pulses", 32'(pulses), 1);
        apply(1'b0, 0, 3'd3, 8'h00, 1'b1, 1'b1, 1'b1);
        check("mode11 AC", 32'(s_dout), 32'hED);
        apply(1'b0, 0, 3'd2, 8'h00, 1'b1, 1'b1, 1'b1);
        check("mode11 WC", 32'(s_dout), 32'hF4);

        // Reset during a count cycle clears every channel.
        apply(1'b1, 0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < N; c++) begin
            for (int op = 1; op <= 3; op++) begin
                apply(1'b0, c, 3'(op), 8'h00, 1'b0, 1'b1, 1'b1);
                check("post-reset read", 32'(s_dout), 0);
                check("post-reset done", 32'(s_done), 0);
            end
        end

        // Random traffic biased toward small values so done conditions occur.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] op;
            logic [7:0] d;
            op = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 6)) : 3'd7;
            d  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            apply($urandom_range(0, 199) == 0, int'($urandom_range(0, N - 1)), op, d,
                  1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
